// File: rtl/score_keeper_pkg.sv
// Shared constants for the note scorer and the downstream level/glyph stage:
// state encodings, rest code, default penalties, score width and helpers.
package score_keeper_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [3:0] REST_CODE = 4'd0;

  localparam int DEF_TIMEOUT_MS = 1000;
  localparam int DEF_MISS_PEN   = 100;
  localparam int DEF_WRONG_PEN  = 50;
  localparam int DEF_RT_SHIFT   = 3;

  localparam int SCORE_W = 14;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  localparam int STREAK_RT_LIMIT = 64;
  localparam int STREAK_BONUS    = 20;

  // Codes 8..15 behave like a rest.
  function automatic logic is_rest(input logic [3:0] code);
    return (code == REST_CODE) || code[3];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W:0]   b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + b;
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/score_keeper_key_edge.sv
// Key press detector: registers the debounced keys once and classifies
// rising edges as a hit on the expected key or a wrong key.
module score_keeper_key_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] key_in,
  input  logic [2:0] exp_key,
  output logic [6:0] edges,
  output logic       hit,
  output logic       wrong
);

  logic [6:0] key_q;
  logic [6:0] target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
    end else begin
      key_q <= key_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_target
      assign target[gi] = (exp_key == 3'(gi + 1));
    end
  endgenerate

  assign edges = key_in & ~key_q;
  assign hit   = |(edges & target);
  assign wrong = |(edges & ~target);

endmodule

// File: rtl/score_keeper.sv
// Per-note performance scorer. Optional build macro: SCORE_STREAK_EN
// (fast-note streak bonus); without it every correct note adds its reaction penalty.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter int MISS_PEN   = DEF_MISS_PEN,
  parameter int WRONG_PEN  = DEF_WRONG_PEN,
  parameter int RT_SHIFT   = DEF_RT_SHIFT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_ms,
  input  logic               start,
  input  logic               note_start,
  input  logic [3:0]         exp_key,
  input  logic [6:0]         key_in,
  input  logic               song_end,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               note_done,
  output logic [7:0]         miss_cnt
);

  logic [1:0]         state, state_next;
  logic [2:0]         exp_note, exp_next;
  logic [9:0]         rt, rt_next;
  logic [SCORE_W-1:0] score_next;
  logic [7:0]         miss_next;
  logic               done_next;
  logic [6:0]         edges;
  logic               hit, wrong;
  logic               ev_miss, ev_wrong, ev_hit;
  logic [SCORE_W:0]   rt_pen;

`ifdef SCORE_STREAK_EN
  logic [1:0] streak, streak_next;
`endif

  score_keeper_key_edge u_key_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .exp_key (exp_note),
    .edges   (edges),
    .hit     (hit),
    .wrong   (wrong)
  );

  assign rt_pen = (SCORE_W + 1)'(rt >> RT_SHIFT);

  always_comb begin
    state_next = state;
    exp_next   = exp_note;
    rt_next    = rt;
    score_next = score;
    miss_next  = miss_cnt;
    done_next  = 1'b0;
    ev_miss    = 1'b0;
    ev_wrong   = 1'b0;
    ev_hit     = 1'b0;
`ifdef SCORE_STREAK_EN
    streak_next = streak;
`endif

    case (state)
      ST_ARMED: begin
        if (song_end) begin
          state_next = ST_DONE;
        end else if (note_start && !is_rest(exp_key)) begin
          exp_next   = exp_key[2:0];
          rt_next    = '0;
          state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (song_end) begin
          ev_miss    = 1'b1;
          state_next = ST_DONE;
        end else if (note_start) begin
          // Open note is abandoned as a miss; the new note starts fresh.
          ev_miss    = 1'b1;
          exp_next   = exp_key[2:0];
          rt_next    = '0;
          state_next = is_rest(exp_key) ? ST_ARMED : ST_MEASURE;
        end else if (rt == 10'(TIMEOUT_MS)) begin
          ev_miss    = 1'b1;
          state_next = ST_ARMED;
        end else if (|edges) begin
          ev_wrong   = wrong;
          ev_hit     = hit && !wrong;
          state_next = ST_ARMED;
        end else if (tick_ms) begin
          rt_next = rt + 10'd1;
        end
      end
      default: ;
    endcase

    if (ev_miss || ev_wrong) begin
      score_next = sat_add(score, ev_miss ? (SCORE_W + 1)'(MISS_PEN) : (SCORE_W + 1)'(WRONG_PEN));
      miss_next  = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
      done_next  = 1'b1;
`ifdef SCORE_STREAK_EN
      streak_next = '0;
`endif
    end else if (ev_hit) begin
      done_next = 1'b1;
`ifdef SCORE_STREAK_EN
      if (rt < 10'(STREAK_RT_LIMIT)) begin
        if (streak == 2'd3) begin
          score_next  = (score < SCORE_W'(STREAK_BONUS)) ? '0 : score - SCORE_W'(STREAK_BONUS);
          streak_next = '0;
        end else begin
          score_next  = sat_add(score, rt_pen);
          streak_next = streak + 2'd1;
        end
      end else begin
        score_next  = sat_add(score, rt_pen);
        streak_next = '0;
      end
`else
      score_next = sat_add(score, rt_pen);
`endif
    end

    if (start) begin
      state_next = ST_ARMED;
      rt_next    = '0;
      score_next = '0;
      miss_next  = '0;
      done_next  = 1'b0;
`ifdef SCORE_STREAK_EN
      streak_next = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      exp_note  <= '0;
      rt        <= '0;
      score     <= '0;
      miss_cnt  <= '0;
      note_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      exp_note  <= exp_next;
      rt        <= rt_next;
      score     <= score_next;
      miss_cnt  <= miss_next;
      note_done <= done_next;
      busy      <= (state_next == ST_ARMED) || (state_next == ST_MEASURE);
    end
  end

`ifdef SCORE_STREAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= '0;
    end else begin
      streak <= streak_next;
    end
  end
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Randomized plus directed bench for score_keeper against a behavioural
// scoring model (song phase, open note, elapsed ms, integer score).
module tb_score_keeper;

  localparam int TIMEOUT  = 1000;
  localparam int MISS_P   = 100;
  localparam int WRONG_P  = 50;
  localparam int SHIFT    = 3;
  localparam int SMAX     = 16383;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_ms = 1'b0;
  logic        start = 1'b0;
  logic        note_start = 1'b0;
  logic [3:0]  exp_key = '0;
  logic [6:0]  key_in = '0;
  logic        song_end = 1'b0;
  logic [13:0] score;
  logic        busy;
  logic        note_done;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 song running, 2 note open, 3 song over.
  int m_phase, m_target, m_elapsed, m_score, m_miss, m_streak, m_done;
  int m_keys_prev;

  score_keeper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_ms    (tick_ms),
    .start      (start),
    .note_start (note_start),
    .exp_key    (exp_key),
    .key_in     (key_in),
    .song_end   (song_end),
    .score      (score),
    .busy       (busy),
    .note_done  (note_done),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic penalize(input int pen);
    m_score  = (m_score + pen > SMAX) ? SMAX : m_score + pen;
    m_miss   = (m_miss < 255) ? m_miss + 1 : 255;
    m_streak = 0;
    m_done   = 1;
  endtask

  task automatic correct(input int ms);
    m_done = 1;
`ifdef SCORE_STREAK_EN
    if (ms < 64) begin
      m_streak++;
      if (m_streak == 4) begin
        m_score  = (m_score < 20) ? 0 : m_score - 20;
        m_streak = 0;
        return;
      end
    end else begin
      m_streak = 0;
    end
`endif
    m_score = (m_score + (ms >> SHIFT) > SMAX) ? SMAX : m_score + (ms >> SHIFT);
  endtask

  function automatic bit valid_note(input int code);
    return code >= 1 && code <= 7;
  endfunction

  task automatic model_cycle(input bit r, input bit st, input bit ns, input int ek,
                             input int keys, input bit tk, input bit se);
    int pressed;
    pressed = keys & ~m_keys_prev;
    m_keys_prev = r ? keys : 0;
    m_done = 0;
    if (!r) begin
      m_phase = 0; m_score = 0; m_miss = 0; m_elapsed = 0; m_streak = 0; m_target = 0;
    end else if (st) begin
      m_phase = 1; m_score = 0; m_miss = 0; m_elapsed = 0; m_streak = 0;
    end else if (m_phase == 1) begin
      if (se) m_phase = 3;
      else if (ns && valid_note(ek)) begin
        m_target = ek; m_elapsed = 0; m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (se) begin
        penalize(MISS_P); m_phase = 3;
      end else if (ns) begin
        penalize(MISS_P);
        m_elapsed = 0;
        if (valid_note(ek)) m_target = ek; else m_phase = 1;
      end else if (m_elapsed == TIMEOUT) begin
        penalize(MISS_P); m_phase = 1;
      end else if (pressed != 0) begin
        if ((pressed & ~(1 << (m_target - 1))) != 0) penalize(WRONG_P);
        else correct(m_elapsed);
        m_phase = 1;
      end else if (tk) begin
        m_elapsed++;
      end
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit ns, input int ek,
                       input int keys, input bit tk, input bit se);
    rst_n = r; start = st; note_start = ns; exp_key = 4'(ek);
    key_in = 7'(keys); tick_ms = tk; song_end = se;
    model_cycle(r, st, ns, ek, keys, tk, se);
    @(posedge clk);
    #1;
    if (m_done != 0)
      $display("note scored: score=%0d miss_cnt=%0d (dut %0d/%0d)", m_score, m_miss, score, miss_cnt);
    check("score", int'(score), m_score);
    check("miss_cnt", int'(miss_cnt), m_miss);
    check("note_done", int'(note_done), m_done);
    check("busy", int'(busy), (m_phase == 1 || m_phase == 2) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    m_keys_prev = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 3, 7'h7f, 1, 0);
    check("reset_score", int'(score), 0);
    check("reset_busy", int'(busy), 0);

    // Correct key after 80 ms.
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 3, 0, 0, 0);
    ticks(80);
    drive(1, 0, 0, 0, 7'b0000100, 0, 0);
    check("hit_score", int'(score), 10);
    check("hit_done", int'(note_done), 1);
    idle(1);
    check("hit_done_pulse", int'(note_done), 0);

    // Timeout after 1000 ms.
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 5, 0, 0, 0);
    ticks(TIMEOUT);
    check("no_early_timeout", int'(miss_cnt), 0);
    idle(1);
    check("timeout_score", int'(score), 100);
    check("timeout_miss", int'(miss_cnt), 1);

    // Correct and wrong edges together count as wrong.
    drive(1, 0, 1, 1, 0, 0, 0);
    ticks(5);
    drive(1, 0, 0, 0, 7'b0010001, 0, 0);
    check("wrong_score", int'(score), 150);
    check("wrong_miss", int'(miss_cnt), 2);
    idle(1);

    // Saturation of score and miss counter.
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 165; i++) drive(1, 0, 1, 2, 0, 0, 0);
    check("sat_score", int'(score), SMAX);
    drive(1, 0, 1, 2, 0, 0, 0);
    check("sat_hold", int'(score), SMAX);
    for (int i = 0; i < 100; i++) drive(1, 0, 1, 2, 0, 0, 0);
    check("miss_sat", int'(miss_cnt), 255);

    // song_end beats note_start while measuring.
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 4, 0, 0, 0);
    ticks(3);
    drive(1, 0, 1, 6, 0, 0, 1);
    check("end_score", int'(score), 100);
    check("end_busy", int'(busy), 0);
    idle(2);
    drive(1, 1, 0, 0, 0, 0, 0);
    check("restart_score", int'(score), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int keys;
      keys = ($urandom_range(0, 3) == 0) ? (1 << $urandom_range(0, 6)) : 0;
      if ($urandom_range(0, 40) == 0) keys = int'($urandom_range(0, 127));
      drive(($urandom_range(0, 1500) != 0),
            ($urandom_range(0, 300) == 0),
            ($urandom_range(0, 25) == 0),
            int'($urandom_range(0, 15)),
            keys,
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 400) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
